// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller: FSM states, legal
// oversampling ratios and the sample-point offset.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8    = 6'd8;
  localparam logic [5:0] PRESCALE_16   = 6'd16;
  localparam logic [5:0] PRESCALE_32   = 6'd32;
  localparam logic [5:0] SAMP_OFFSET   = 6'd2;
  localparam logic [3:0] LAST_DATA_BIT = 4'd8;

  // Unsupported ratios fall back to the slowest legal oversampling of 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    logic [5:0] r;
    case (p)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: r = p;
      default:                              r = PRESCALE_8;
    endcase
    return r;
  endfunction

  // The sampler votes on edges P/2-1..P/2+1, so its result settles at P/2+2.
  function automatic logic [5:0] sample_point(input logic [5:0] p);
    return {1'b0, p[5:1]} + SAMP_OFFSET;
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter; wraps edge_cnt at the
// latched prescale and advances bit_cnt on each wrap.
module edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  input  logic [5:0] prescale,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       wrap
);

  assign wrap = enable && (edge_cnt == (prescale - 6'd1));

  // Counter registers; clear has priority so a new frame always starts at 0/0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (clear) begin
      edge_cnt <= 6'd0;
      bit_cnt  <= 4'd0;
    end else if (enable) begin
      if (wrap) begin
        edge_cnt <= 6'd0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, per-frame configuration latch, error
// latches and the one-cycle strobes for sampler, deserializer and checkers.
module uart_rx_ctrl
  import uart_rx_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       par_err,
  input  logic       strt_glitch,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       data_valid
);

  rx_state_e  state_r, state_s;
  logic [5:0] prescale_r;
  logic       par_en_r;
  logic       par_err_r;
  logic       stp_err_r;
  logic       armed_r;

  logic [5:0] samp_s;
  logic       at_samp_s;
  logic       at_chk_s;
  logic       wrap_s;
  logic       restart_s;
  logic       cnt_en_s;
  logic       cnt_clear_s;

  assign samp_s    = sample_point(prescale_r);
  assign at_samp_s = (edge_cnt == samp_s);
  assign at_chk_s  = (edge_cnt == (samp_s + 6'd1));

  // A frame starts from IDLE or directly from the end of a previous STOP.
  assign restart_s   = (state_s == ST_START) && (state_r != ST_START);
  assign cnt_en_s    = (state_r != ST_IDLE);
  assign cnt_clear_s = restart_s || (state_s == ST_IDLE);

  edge_bit_counter u_cnt (
    .clk      (CLK),
    .rst_n    (RST_n),
    .enable   (cnt_en_s),
    .clear    (cnt_clear_s),
    .prescale (prescale_r),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap_s)
  );

  // Next-state logic; a start glitch wins over the bit boundary when both coincide.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (armed_r && !RX_IN) state_s = ST_START;
        else                   state_s = ST_IDLE;
      end
      ST_START: begin
        if (at_chk_s && strt_glitch) state_s = ST_IDLE;
        else if (wrap_s)             state_s = ST_DATA;
        else                         state_s = ST_START;
      end
      ST_DATA: begin
        if (wrap_s && (bit_cnt == LAST_DATA_BIT)) state_s = par_en_r ? ST_PARITY : ST_STOP;
        else                                      state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (wrap_s) state_s = ST_STOP;
        else        state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (wrap_s) state_s = RX_IN ? ST_IDLE : ST_START;
        else        state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Per-frame configuration and error latches, refreshed at every frame start.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prescale_r <= PRESCALE_8;
      par_en_r   <= 1'b0;
      par_err_r  <= 1'b0;
      stp_err_r  <= 1'b0;
    end else if (restart_s) begin
      prescale_r <= legal_prescale(Prescale);
      par_en_r   <= PAR_EN;
      par_err_r  <= 1'b0;
      stp_err_r  <= 1'b0;
    end else begin
      if ((state_r == ST_PARITY) && at_chk_s && par_err) par_err_r <= 1'b1;
      if ((state_r == ST_STOP) && at_chk_s && stp_err)   stp_err_r <= 1'b1;
    end
  end

  // After reset the line must be seen high before a low level counts as a start.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) armed_r <= 1'b0;
    else        armed_r <= armed_r | RX_IN;
  end

  // Strobe decode from registered state and counters only.
  always_comb begin
    dat_samp_en = (state_r != ST_IDLE);
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state_r)
      ST_START:  strt_chk_en = at_samp_s;
      ST_DATA:   deser_en    = at_samp_s;
      ST_PARITY: par_chk_en  = at_samp_s;
      ST_STOP: begin
        stp_chk_en = at_samp_s;
        // At Prescale=8 the stop flag arrives on the last edge, so it is used live.
        data_valid = wrap_s && !par_err_r && !stp_err_r && !(at_chk_s && stp_err);
      end
      default: dat_samp_en = (state_r != ST_IDLE);
    endcase
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001: CLK  input  1  receiver oversampling clock; all state SHALL update on its rising edge.
REQ-002: RST_n  input  1  asynchronous active-low reset.
REQ-003: RX_IN  input  1  serial line; idle high; frame = start(0), 8 data LSB-first, optional parity, stop(1).
REQ-004: PAR_EN  input  1  parity bit present when 1.
REQ-005: Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-006: par_err, strt_glitch, stp_err  input  1 each  registered checker flags, valid the cycle after the matching check enable.
REQ-007: edge_cnt  output  6  position within the current bit, 0..Prescale-1.
REQ-008: bit_cnt  output  4  frame bit index: 0 start, 1..8 data, 9 parity or stop, 10 stop with parity.
REQ-009: dat_samp_en  output  1  sampler enable, high in every non-IDLE state.
REQ-010: deser_en  output  1  one-cycle load strobe to the deserializer.
REQ-011: strt_chk_en, par_chk_en, stp_chk_en  output  1 each  one-cycle checker strobes.
REQ-012: data_valid  output  1  one-cycle pulse: deserializer byte is good.

Function
REQ-013: States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014: Prescale SHALL be latched on IDLE->START; other values SHALL be treated as 8.
REQ-015: IDLE->START SHALL occur on the first cycle RX_IN is sampled 0; edge_cnt=0, bit_cnt=0 in that next cycle.
REQ-016: In non-IDLE states edge_cnt SHALL increment each cycle; at Prescale-1 it SHALL wrap to 0 and bit_cnt SHALL increment.
REQ-017: Sample point S = Prescale/2+2 (sampler majority of edges P/2-1, P/2, P/2+1 is then stable).
REQ-018: START: strt_chk_en SHALL pulse at edge_cnt=S; strt_glitch=1 at S+1 SHALL force IDLE next cycle, no strobes issued.
REQ-019: START->DATA SHALL occur at bit boundary (bit_cnt 0->1).
REQ-020: DATA: deser_en SHALL pulse at edge_cnt=S for bit_cnt 1..8, exactly 8 pulses per frame.
REQ-021: DATA exit at bit_cnt 8 wrap: PARITY if PAR_EN else STOP.
REQ-022: PARITY: par_chk_en SHALL pulse at S; par_err at S+1 SHALL be latched for the frame.
REQ-023: STOP: stp_chk_en SHALL pulse at S; stp_err at S+1 SHALL be latched.
REQ-024: data_valid SHALL pulse at STOP edge_cnt=Prescale-1 iff neither error latched; error latches SHALL clear on IDLE->START.
REQ-025: At STOP end: RX_IN=0 that cycle -> START directly (back-to-back frames, no idle cycle); else IDLE.
REQ-026: PAR_EN SHALL be latched with Prescale; changes mid-frame SHALL have no effect.
REQ-027: In IDLE edge_cnt, bit_cnt SHALL hold 0 and all strobes 0.
REQ-028: At most one of deser_en/strt_chk_en/par_chk_en/stp_chk_en SHALL be high in any cycle.

Reset
REQ-029: RST_n low SHALL asynchronously force IDLE, edge_cnt=0, bit_cnt=0, all strobes 0, data_valid=0, latched errors 0, latched Prescale=8, PAR_EN=0.
REQ-030: Reset mid-frame SHALL abort the frame with no data_valid; after release a frame SHALL need a fresh RX_IN falling level.

Structure
REQ-031: State encoding, legal Prescale constants and S offset SHALL live in shared package uart_rx_pkg.
REQ-032: Edge/bit counter SHALL be one sub-module, edge_bit_counter (enable, latched Prescale -> edge_cnt, bit_cnt, wrap).
REQ-033: FSM and error latches SHALL be in uart_rx_ctrl; no other sub-modules.

Verification
REQ-034: Prescale=8, PAR_EN=0, frame 0xA5 -> deser_en at edge_cnt 6 of bits 1..8, data_valid once at cycle 79 after start detect.
REQ-035: Prescale=16, PAR_EN=1, even parity, par_err=1 after par_chk_en -> no data_valid, return to IDLE after bit 10.
REQ-036: Prescale=32, RX_IN low 4 cycles then high, strt_glitch=1 -> IDLE at edge_cnt 19, zero deser_en pulses.
REQ-037: Two back-to-back frames Prescale=16 -> two data_valid pulses 160 cycles apart, no IDLE between.
REQ-038: RST_n low at bit_cnt=4 -> all outputs 0 same cycle, no data_valid, next frame received normally.
REQ-039: Prescale=20 -> behaves as 8; stp_err=1 -> no data_valid.
